// File: rtl/u_dmem_pkg.sv
// u_dmem_pkg: shared memory widths and FSM state encoding for the data-memory master
package u_dmem_pkg;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    VGAP    = 3'd4,
    VSTROBE = 3'd5
  } state_t;
endpackage

// File: rtl/u_data_mem_master.sv
// u_data_mem_master: valid/ready to one-cycle read/write strobe bridge for the 2048x16 data memory (U_DMEM_WRITE_VERIFY_EN adds write read-back verify)
module u_data_mem_master #(
  parameter int ADDR_W = u_dmem_pkg::ADDR_W,
  parameter int DATA_W = u_dmem_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [CNT_W-1:0]  txn_count,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] mem_out_data
);
  import u_dmem_pkg::*;
  state_t state, state_n;
  logic   we_q;
  assign req_ready = (state == IDLE) & ~reset;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_valid ? SETUP : IDLE;
      SETUP:   state_n = STROBE;
`ifdef U_DMEM_WRITE_VERIFY_EN
      STROBE:  state_n = we_q ? VGAP : HOLD;
      VGAP:    state_n = VSTROBE;
      VSTROBE: state_n = HOLD;
`else
      STROBE:  state_n = HOLD;
`endif
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      we_q        <= 1'b0;
      mem_address <= '0;
      mem_in_data <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      txn_count   <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q        <= req_we;
        mem_address <= req_addr;
        mem_in_data <= req_wdata;
      end
      mem_read   <= (state_n == STROBE && !we_q) || state_n == VSTROBE;
      mem_write  <= state_n == STROBE && we_q;
      resp_valid <= state_n == HOLD;
      if (state == STROBE && !we_q) resp_rdata <= mem_out_data;
      if (state_n == HOLD) txn_count <= txn_count + CNT_W'(1);
    end
`ifdef U_DMEM_WRITE_VERIFY_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) resp_err <= 1'b0;
    else resp_err <= state == VSTROBE && mem_out_data != mem_in_data;
`else
  assign resp_err = 1'b0;
`endif
endmodule

// File: tb/tb_u_data_mem_master.sv
// tb_u_data_mem_master: directed table-driven bench for u_data_mem_master with a behavioural strobe-driven memory
module tb_u_data_mem_master;
`ifdef U_DMEM_WRITE_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [10:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [15:0] resp_rdata, txn_count, mem_in_data, mem_out_data;
  logic [10:0] mem_address;
  logic        r2_ready, r2_valid, r2_err, r2_rd, r2_wr;
  logic [15:0] r2_rdata, r2_wd;
  logic [10:0] r2_addr;
  logic [1:0]  cnt2;
  logic [15:0] mem [int];
  logic [15:0] mem_q = '0;
  logic        corrupt = 1'b0;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  assign mem_out_data = corrupt ? 16'hBEEE : mem_q;
  always @(posedge mem_write) mem[int'(mem_address)] = mem_in_data;
  always @(posedge mem_read) mem_q = mem.exists(int'(mem_address)) ? mem[int'(mem_address)] : 16'h0000;
  u_data_mem_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .txn_count(txn_count), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_in_data(mem_in_data), .mem_out_data(mem_out_data)
  );
  u_data_mem_master #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r2_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r2_valid), .resp_rdata(r2_rdata),
    .resp_err(r2_err), .txn_count(cnt2), .mem_read(r2_rd), .mem_write(r2_wr),
    .mem_address(r2_addr), .mem_in_data(r2_wd), .mem_out_data(mem_out_data)
  );
  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_txn(input logic we, input logic [10:0] a, input logic [15:0] d,
                         output int lat, output int rdh, output int wrh,
                         output logic [15:0] rd, output logic er);
    lat = -1;
    rdh = 0;
    wrh = 0;
    rd = '0;
    er = 1'b0;
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 10 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        chk("strobe_overlap", {31'd0, mem_read & mem_write}, 32'd0);
        chk("strobe_addr", {21'd0, mem_address}, {21'd0, a});
      end
      rdh += int'(mem_read);
      wrh += int'(mem_write);
      if (resp_valid) begin
        lat = c;
        rd = resp_rdata;
        er = resp_err;
      end
    end
    @(negedge clk);
    chk("resp_valid_pulse", {31'd0, resp_valid}, 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    int lat, rdh, wrh, n, exp_cnt;
    int acc [3];
    logic [15:0] rd;
    logic er, seen;
    tbl[0] = '{1'b0, 11'h7FF, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 11'h005, 16'h1234, 16'h0000};
    tbl[2] = '{1'b0, 11'h005, 16'h0000, 16'h1234};
    tbl[3] = '{1'b1, 11'h400, 16'hA5A5, 16'h1234};
    tbl[4] = '{1'b0, 11'h400, 16'h0000, 16'hA5A5};
    tbl[5] = '{1'b1, 11'h000, 16'hFFFF, 16'hA5A5};
    tbl[6] = '{1'b0, 11'h000, 16'h0000, 16'hFFFF};
    tbl[7] = '{1'b0, 11'h005, 16'h0000, 16'h1234};
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_txn_count", {16'd0, txn_count}, 32'd0);
    chk("rst_mem_address", {21'd0, mem_address}, 32'd0);
    chk("rst_resp_rdata", {16'd0, resp_rdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rdh, wrh, rd, er);
      exp_cnt++;
      chk($sformatf("latency[%0d]", i), lat, (tbl[i].we && VER) ? 32'd4 : 32'd2);
      chk($sformatf("rdata[%0d]", i), {16'd0, rd}, {16'd0, tbl[i].rdata});
      chk($sformatf("err[%0d]", i), {31'd0, er}, 32'd0);
      chk($sformatf("rd_strobe_cycles[%0d]", i), rdh, (!tbl[i].we || VER) ? 32'd1 : 32'd0);
      chk($sformatf("wr_strobe_cycles[%0d]", i), wrh, tbl[i].we ? 32'd1 : 32'd0);
      chk($sformatf("txn_count[%0d]", i), {16'd0, txn_count}, exp_cnt);
      chk($sformatf("txn_count_wrap2[%0d]", i), {30'd0, cnt2}, exp_cnt % 4);
    end
`ifdef U_DMEM_WRITE_VERIFY_EN
    run_txn(1'b1, 11'h010, 16'hBEEF, lat, rdh, wrh, rd, er);
    exp_cnt++;
    chk("verify_ok_latency", lat, 32'd4);
    chk("verify_ok_err", {31'd0, er}, 32'd0);
    chk("verify_ok_rdata_kept", {16'd0, rd}, 32'h1234);
    corrupt = 1'b1;
    run_txn(1'b1, 11'h010, 16'hBEEF, lat, rdh, wrh, rd, er);
    corrupt = 1'b0;
    exp_cnt++;
    chk("verify_bad_latency", lat, 32'd4);
    chk("verify_bad_err", {31'd0, er}, 32'd1);
`endif
    n = 0;
    acc = '{0, 0, 0};
    req_we = 1'b0;
    req_addr = 11'h005;
    req_valid = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (mem_read || mem_write) begin
        chk("b2b_strobe_overlap", {31'd0, mem_read & mem_write}, 32'd0);
        chk("b2b_strobe_addr", {21'd0, mem_address}, 32'h005);
      end
      if (req_ready) begin
        acc[n] = c;
        n++;
      end
      if (n < 3) @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    exp_cnt += 3;
    chk("b2b_accepts", n, 32'd3);
    chk("b2b_gap01", acc[1] - acc[0], 32'd4);
    chk("b2b_gap12", acc[2] - acc[1], 32'd4);
    chk("b2b_txn_count", {16'd0, txn_count}, exp_cnt);
    chk("b2b_rdata", {16'd0, resp_rdata}, 32'h1234);
    chk("b2b_idle", {31'd0, req_ready}, 32'd1);
    req_we = 1'b0;
    req_addr = 11'h7FF;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 5 && !mem_read; c++) @(negedge clk);
    chk("pre_reset_mem_read", {31'd0, mem_read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("async_rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("async_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("async_rst_txn_count", {16'd0, txn_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    chk("post_rst_no_resp", {31'd0, seen}, 32'd0);
    chk("post_rst_txn_count", {16'd0, txn_count}, 32'd0);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_rdata", {16'd0, resp_rdata}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
